pipe_ctrl: RTL and testbench

Owns the five-stage pipeline's state: the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It consumes the stall/flush commands produced by the hazard unit and applies them cycle by cycle as holds, bubbles and fetch redirects. A data-memory busy signal freezes the whole pipeline. The datapath presents each stage's next-state struct; this block decides what is actually latched.

---
 rtl/pipe_ctrl_pkg.sv | 51 +++++
 rtl/pipe_reg.sv | 36 +++
 rtl/pipe_ctrl.sv | 133 +++++++++++++
 tb/tb_pipe_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline stage types, bubble constants and the default reset PC for pipe_ctrl.
// Bubbles are all-zero so that a cleared register is invalid, with ctrl off and rd=0.
package pipe_ctrl_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
  } ctrl_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } IF_ID_t;

  typedef struct packed {
    logic        valid;
    ctrl_t       ctrl;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
  } ID_EX_t;

  typedef struct packed {
    logic        valid;
    ctrl_t       ctrl;
    logic [4:0]  rd;
    logic [31:0] alu_res;
    logic [31:0] store_data;
  } EX_MEM_t;

  typedef struct packed {
    logic        valid;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] wb_data;
  } MEM_WB_t;

  localparam IF_ID_t  IF_ID_BUBBLE  = '0;
  localparam ID_EX_t  ID_EX_BUBBLE  = '0;
  localparam EX_MEM_t EX_MEM_BUBBLE = '0;
  localparam MEM_WB_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: reset/clear load the bubble value, hold keeps contents.
// Hold outranks clear; the caller folds flush-over-stall priority into hold_i/clear_i.
module pipe_reg #(
  parameter type T      = logic,
  parameter T    Bubble = T'('0)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic hold_i,
  input  logic clear_i,
  input  T     d_i,
  output T     q_o
);

  T q_q, q_d;

  always_comb begin
    q_d = d_i;
    if (hold_i) begin
      q_d = q_q;
    end else if (clear_i) begin
      q_d = Bubble;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= Bubble;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline state owner: PC plus four stage registers, applying hazard stall/flush commands.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_if_i,
  input  logic        stall_id_i,
  input  logic        stall_ex_i,
  input  logic        flush_if_i,
  input  logic        flush_id_i,
  input  logic        flush_ex_i,
  input  logic [31:0] redirect_pc_i,
  input  logic [31:0] pc_plus4_i,
  input  logic        mem_busy_i,
  input  IF_ID_t      if_id_d_i,
  input  ID_EX_t      id_ex_d_i,
  input  EX_MEM_t     ex_mem_d_i,
  input  MEM_WB_t     mem_wb_d_i,
  output logic [31:0] pc_o,
  output IF_ID_t      if_id_o,
  output ID_EX_t      id_ex_o,
  output EX_MEM_t     ex_mem_o,
  output MEM_WB_t     mem_wb_o
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] perf_cycles_o,
  output logic [31:0] perf_retired_o,
  output logic [31:0] perf_stalls_o,
  output logic [31:0] perf_flushes_o
`endif
);

  logic [31:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_plus4_i;
    if (mem_busy_i) begin
      pc_d = pc_q;
    end else if (flush_if_i) begin
      pc_d = redirect_pc_i;
    end else if (stall_if_i) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

  // A flush beats a stall on the same register, so stall only holds when not flushed.
  logic if_id_hold, if_id_clear;
  logic id_ex_hold, id_ex_clear;
  logic ex_mem_clear;

  always_comb begin
    if_id_hold   = mem_busy_i | (stall_id_i & ~flush_id_i);
    if_id_clear  = ~mem_busy_i & flush_id_i;
    id_ex_hold   = mem_busy_i | (stall_ex_i & ~flush_ex_i);
    id_ex_clear  = ~mem_busy_i & (flush_ex_i | (stall_id_i & ~stall_ex_i));
    ex_mem_clear = ~mem_busy_i & stall_ex_i;
  end

  pipe_reg #(.T(IF_ID_t), .Bubble(IF_ID_BUBBLE)) u_if_id (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .hold_i  (if_id_hold),
    .clear_i (if_id_clear),
    .d_i     (if_id_d_i),
    .q_o     (if_id_o)
  );

  pipe_reg #(.T(ID_EX_t), .Bubble(ID_EX_BUBBLE)) u_id_ex (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .hold_i  (id_ex_hold),
    .clear_i (id_ex_clear),
    .d_i     (id_ex_d_i),
    .q_o     (id_ex_o)
  );

  // Never flushed: the control transfer resolving in EX must still reach writeback.
  pipe_reg #(.T(EX_MEM_t), .Bubble(EX_MEM_BUBBLE)) u_ex_mem (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .hold_i  (mem_busy_i),
    .clear_i (ex_mem_clear),
    .d_i     (ex_mem_d_i),
    .q_o     (ex_mem_o)
  );

  pipe_reg #(.T(MEM_WB_t), .Bubble(MEM_WB_BUBBLE)) u_mem_wb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .hold_i  (mem_busy_i),
    .clear_i (1'b0),
    .d_i     (mem_wb_d_i),
    .q_o     (mem_wb_o)
  );

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] cycles_q, retired_q, stalls_q, flushes_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycles_q  <= '0;
      retired_q <= '0;
      stalls_q  <= '0;
      flushes_q <= '0;
    end else begin
      cycles_q <= cycles_q + 32'd1;
      if (mem_wb_o.valid && !mem_busy_i) retired_q <= retired_q + 32'd1;
      if (stall_if_i || mem_busy_i)      stalls_q  <= stalls_q + 32'd1;
      if (flush_if_i && !mem_busy_i)     flushes_q <= flushes_q + 32'd1;
    end
  end

  assign perf_cycles_o  = cycles_q;
  assign perf_retired_o = retired_q;
  assign perf_stalls_o  = stalls_q;
  assign perf_flushes_o = flushes_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: action table, hand-written corner sequences, then random commands
// checked against a per-register action model (perf counters checked when PIPE_PERF_CNT_EN).
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam logic [31:0] RstPc = 32'h100;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_if_i = 1'b0, stall_id_i = 1'b0, stall_ex_i = 1'b0;
  logic        flush_if_i = 1'b0, flush_id_i = 1'b0, flush_ex_i = 1'b0;
  logic [31:0] redirect_pc_i = '0, pc_plus4_i = '0;
  logic        mem_busy_i = 1'b0;
  IF_ID_t      if_id_d_i = '0;
  ID_EX_t      id_ex_d_i = '0;
  EX_MEM_t     ex_mem_d_i = '0;
  MEM_WB_t     mem_wb_d_i = '0;
  logic [31:0] pc_o;
  IF_ID_t      if_id_o;
  ID_EX_t      id_ex_o;
  EX_MEM_t     ex_mem_o;
  MEM_WB_t     mem_wb_o;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_cycles_o, perf_retired_o, perf_stalls_o, perf_flushes_o;
`endif

  always #5 clk = ~clk;

  pipe_ctrl #(.RESET_PC(RstPc)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .stall_if_i    (stall_if_i),
    .stall_id_i    (stall_id_i),
    .stall_ex_i    (stall_ex_i),
    .flush_if_i    (flush_if_i),
    .flush_id_i    (flush_id_i),
    .flush_ex_i    (flush_ex_i),
    .redirect_pc_i (redirect_pc_i),
    .pc_plus4_i    (pc_plus4_i),
    .mem_busy_i    (mem_busy_i),
    .if_id_d_i     (if_id_d_i),
    .id_ex_d_i     (id_ex_d_i),
    .ex_mem_d_i    (ex_mem_d_i),
    .mem_wb_d_i    (mem_wb_d_i),
    .pc_o          (pc_o),
    .if_id_o       (if_id_o),
    .id_ex_o       (id_ex_o),
    .ex_mem_o      (ex_mem_o),
    .mem_wb_o      (mem_wb_o)
`ifdef PIPE_PERF_CNT_EN
    ,
    .perf_cycles_o  (perf_cycles_o),
    .perf_retired_o (perf_retired_o),
    .perf_stalls_o  (perf_stalls_o),
    .perf_flushes_o (perf_flushes_o)
`endif
  );

  typedef enum logic [1:0] {ALoad, AHold, ABubble, ARedir} act_e;

  // Table record: {busy, stall_if, stall_id, stall_ex, flush_if, flush_id, flush_ex} + actions.
  typedef struct {
    logic [6:0] cmd;
    act_e       a_pc, a_ifid, a_idex, a_exmem, a_mwb;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected state of the DUT.
  logic [31:0] e_pc;
  IF_ID_t      e_ifid;
  ID_EX_t      e_idex;
  EX_MEM_t     e_exmem;
  MEM_WB_t     e_mwb;
  logic [31:0] e_cyc = '0, e_ret = '0, e_stl = '0, e_fl = '0;

  task automatic check(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_pc"},     192'(pc_o),     192'(e_pc));
    check({tag, "_if_id"},  192'(if_id_o),  192'(e_ifid));
    check({tag, "_id_ex"},  192'(id_ex_o),  192'(e_idex));
    check({tag, "_ex_mem"}, 192'(ex_mem_o), 192'(e_exmem));
    check({tag, "_mem_wb"}, 192'(mem_wb_o), 192'(e_mwb));
`ifdef PIPE_PERF_CNT_EN
    check({tag, "_perf_cycles"},  192'(perf_cycles_o),  192'(e_cyc));
    check({tag, "_perf_retired"}, 192'(perf_retired_o), 192'(e_ret));
    check({tag, "_perf_stalls"},  192'(perf_stalls_o),  192'(e_stl));
    check({tag, "_perf_flushes"}, 192'(perf_flushes_o), 192'(e_fl));
`endif
  endtask

  function automatic logic [191:0] rnd192();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_inputs(input logic [6:0] cmd);
    logic [191:0] r;
    {mem_busy_i, stall_if_i, stall_id_i, stall_ex_i, flush_if_i, flush_id_i, flush_ex_i} = cmd;
    r = rnd192(); if_id_d_i  = IF_ID_t'(r[$bits(IF_ID_t)-1:0]);
    r = rnd192(); id_ex_d_i  = ID_EX_t'(r[$bits(ID_EX_t)-1:0]);
    r = rnd192(); ex_mem_d_i = EX_MEM_t'(r[$bits(EX_MEM_t)-1:0]);
    r = rnd192(); mem_wb_d_i = MEM_WB_t'(r[$bits(MEM_WB_t)-1:0]);
    redirect_pc_i = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
    pc_plus4_i    = e_pc + 32'd4;
  endtask

  // Apply one clock edge with the given per-register actions and compare everything after it.
  task automatic advance(input string tag, input act_e apc, input act_e aif, input act_e aid,
                         input act_e aex, input act_e amw);
    logic [31:0] npc;
    IF_ID_t nif; ID_EX_t nid; EX_MEM_t nex; MEM_WB_t nmw;
    npc = (apc == ALoad) ? pc_plus4_i : (apc == ARedir) ? redirect_pc_i : e_pc;
    nif = (aif == ALoad) ? if_id_d_i  : (aif == AHold) ? e_ifid  : '0;
    nid = (aid == ALoad) ? id_ex_d_i  : (aid == AHold) ? e_idex  : '0;
    nex = (aex == ALoad) ? ex_mem_d_i : (aex == AHold) ? e_exmem : '0;
    nmw = (amw == ALoad) ? mem_wb_d_i : (amw == AHold) ? e_mwb   : '0;
    if (rst_i) begin
      npc = RstPc; nif = '0; nid = '0; nex = '0; nmw = '0;
      e_cyc = '0; e_ret = '0; e_stl = '0; e_fl = '0;
    end else begin
      e_cyc = e_cyc + 1;
      if (e_mwb.valid && !mem_busy_i) e_ret = e_ret + 1;
      if (stall_if_i || mem_busy_i)   e_stl = e_stl + 1;
      if (flush_if_i && !mem_busy_i)  e_fl  = e_fl + 1;
    end
    @(posedge clk);
    #1;
    e_pc = npc; e_ifid = nif; e_idex = nid; e_exmem = nex; e_mwb = nmw;
    compare_all(tag);
  endtask

  // Reference decisions, straight from the per-register priority lists.
  task automatic model_step(input string tag);
    act_e apc, aif, aid, aex, amw;
    if (mem_busy_i) begin
      apc = AHold; aif = AHold; aid = AHold; aex = AHold; amw = AHold;
    end else begin
      apc = flush_if_i ? ARedir : stall_if_i ? AHold : ALoad;
      aif = flush_id_i ? ABubble : stall_id_i ? AHold : ALoad;
      aid = flush_ex_i ? ABubble : stall_ex_i ? AHold : stall_id_i ? ABubble : ALoad;
      aex = stall_ex_i ? ABubble : ALoad;
      amw = ALoad;
    end
    advance(tag, apc, aif, aid, aex, amw);
  endtask

  task automatic do_reset(input int n);
    rst_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      set_inputs(7'b0);
      model_step("reset");
    end
    rst_i = 1'b0;
  endtask

  vec_t tbl[12];

  initial begin
    e_pc = '0; e_ifid = '0; e_idex = '0; e_exmem = '0; e_mwb = '0;
    //            busy si sd se fi fd fe
    tbl[0]  = '{7'b0_000_000, ALoad,  ALoad,   ALoad,   ALoad,   ALoad};
    tbl[1]  = '{7'b0_110_000, AHold,  AHold,   ABubble, ALoad,   ALoad};
    tbl[2]  = '{7'b0_000_111, ARedir, ABubble, ABubble, ALoad,   ALoad};
    tbl[3]  = '{7'b0_010_010, ALoad,  ABubble, ABubble, ALoad,   ALoad};
    tbl[4]  = '{7'b0_001_000, ALoad,  ALoad,   AHold,   ABubble, ALoad};
    tbl[5]  = '{7'b1_111_111, AHold,  AHold,   AHold,   AHold,   AHold};
    tbl[6]  = '{7'b0_111_000, AHold,  AHold,   AHold,   ABubble, ALoad};
    tbl[7]  = '{7'b0_001_001, ALoad,  ALoad,   ABubble, ABubble, ALoad};
    tbl[8]  = '{7'b0_100_100, ARedir, ALoad,   ALoad,   ALoad,   ALoad};
    tbl[9]  = '{7'b0_010_000, ALoad,  AHold,   ABubble, ALoad,   ALoad};
    tbl[10] = '{7'b1_000_000, AHold,  AHold,   AHold,   AHold,   AHold};
    tbl[11] = '{7'b0_011_011, ALoad,  ABubble, ABubble, ABubble, ALoad};

    // Reset for two cycles, then sequential fetch.
    do_reset(2);
    check("reset_pc", 192'(pc_o), 192'(RstPc));
    for (int i = 0; i < 2; i++) begin
      set_inputs(7'b0);
      model_step("seq");
    end
    check("seq_pc", 192'(pc_o), 192'(32'h108));

    // Load-use stall at PC 0x108.
    set_inputs(7'b0_110_000);
    model_step("loaduse");
    check("loaduse_pc", 192'(pc_o), 192'(32'h108));
    check("loaduse_idex_valid", 192'(id_ex_o.valid), 192'(1'b0));

    // Taken branch.
    set_inputs(7'b0_000_111);
    redirect_pc_i = 32'h200;
    model_step("branch");
    check("branch_pc", 192'(pc_o), 192'(32'h200));
    check("branch_ifid_valid", 192'(if_id_o.valid), 192'(1'b0));

    // Freeze for 3 cycles, flush_if in the middle one, then redirect after release.
    for (int i = 0; i < 3; i++) begin
      set_inputs((i == 1) ? 7'b1_000_100 : 7'b1_000_000);
      redirect_pc_i = 32'h200;
      model_step("freeze");
    end
    set_inputs(7'b0_000_100);
    redirect_pc_i = 32'h200;
    model_step("unfreeze");
    check("unfreeze_pc", 192'(pc_o), 192'(32'h200));

    // Action table.
    for (int i = 0; i < 12; i++) begin
      set_inputs(tbl[i].cmd);
      advance($sformatf("tbl%0d", i), tbl[i].a_pc, tbl[i].a_ifid, tbl[i].a_idex,
              tbl[i].a_exmem, tbl[i].a_mwb);
    end

`ifdef PIPE_PERF_CNT_EN
    // 10 cycles: 5 retirements, 2 stall cycles, 1 flush.
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      set_inputs((i == 6 || i == 7) ? 7'b0_110_000 : (i == 8) ? 7'b0_000_111 : 7'b0);
      mem_wb_d_i.valid = (i < 5);
      model_step("perf");
    end
    check("perf_cycles_10",  192'(perf_cycles_o),  192'(32'd10));
    check("perf_retired_5",  192'(perf_retired_o), 192'(32'd5));
    check("perf_stalls_2",   192'(perf_stalls_o),  192'(32'd2));
    check("perf_flushes_1",  192'(perf_flushes_o), 192'(32'd1));
`endif

    // Random commands, with occasional mid-run reset.
    for (int i = 0; i < 400; i++) begin
      logic [6:0] c;
      c[6] = ($urandom_range(0, 5) == 0);
      for (int b = 0; b < 6; b++) c[b] = ($urandom_range(0, 4) == 0);
      set_inputs(c);
      rst_i = ($urandom_range(0, 99) == 0);
      model_step("rand");
    end
    rst_i = 1'b0;

    do_reset(1);
    check("final_reset_pc", 192'(pc_o), 192'(RstPc));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
